// File: rtl/calc_ctrl.sv
// rtl/calc_ctrl.sv - accumulator calculator controller with add/sub/mul and serial restoring divide
// One command per rising edge of go; divide runs one quotient bit per cycle before writing acc.
module calc_ctrl #(
   parameter int ACC_W = 8,
   parameter int VAL_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             go,
   input  logic [1:0]       op,
   input  logic [VAL_W-1:0] val,
   input  logic             clr,
   output logic [ACC_W-1:0] acc,
   output logic [VAL_W-1:0] rem,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic             ovr
);

   localparam int CNT_W = $clog2(ACC_W + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DIV  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic             go_q;
   logic [1:0]       op_q, op_d;
   logic [VAL_W-1:0] val_q, val_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [VAL_W-1:0] rem_q, rem_d;
   logic [ACC_W-1:0] quot_q, quot_d;
   logic [VAL_W-1:0] prem_q, prem_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             done_q, done_d;
   logic             err_q, err_d;
   logic             ovr_q, ovr_d;

   logic             go_edge;
   logic [ACC_W-1:0] val_ext;
   logic [VAL_W:0]   trial;
   logic             trial_ge;

   assign go_edge  = go & ~go_q;
   assign val_ext  = {{(ACC_W-VAL_W){1'b0}}, val_q};
   // quot_q doubles as the dividend shift register; its MSB feeds the partial remainder
   assign trial    = {prem_q, quot_q[ACC_W-1]};
   assign trial_ge = (trial >= {1'b0, val_q});

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         go_q    <= 1'b1;
         op_q    <= '0;
         val_q   <= '0;
         acc_q   <= '0;
         rem_q   <= '0;
         quot_q  <= '0;
         prem_q  <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         go_q    <= go;
         op_q    <= op_d;
         val_q   <= val_d;
         acc_q   <= acc_d;
         rem_q   <= rem_d;
         quot_q  <= quot_d;
         prem_q  <= prem_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         err_q   <= err_d;
         ovr_q   <= ovr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      val_d   = val_q;
      acc_d   = acc_q;
      rem_d   = rem_q;
      quot_d  = quot_q;
      prem_d  = prem_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      err_d   = err_q;
      ovr_d   = ovr_q;
      case (state_q)
         IDLE: begin
            if (clr) begin
               acc_d = '0;
               rem_d = '0;
            end else if (go_edge) begin
               op_d    = op;
               val_d   = val;
               err_d   = 1'b0;
               ovr_d   = 1'b0;
               quot_d  = acc_q;
               prem_d  = '0;
               cnt_d   = '0;
               state_d = (op == 2'b11) ? DIV : EXEC;
            end
         end
         EXEC: begin
            if (go_edge) ovr_d = 1'b1;
            case (op_q)
               2'b00:   acc_d = acc_q + val_ext;
               2'b01:   acc_d = acc_q - val_ext;
               default: acc_d = acc_q * val_ext;
            endcase
            done_d  = 1'b1;
            state_d = IDLE;
         end
         DIV: begin
            if (go_edge) ovr_d = 1'b1;
            if (cnt_q == CNT_W'(ACC_W)) begin
               if (val_q == '0) begin
                  acc_d = '1;
                  rem_d = '1;
                  err_d = 1'b1;
               end else begin
                  acc_d = quot_q;
                  rem_d = prem_q;
               end
               done_d  = 1'b1;
               state_d = IDLE;
            end else begin
               quot_d = {quot_q[ACC_W-2:0], trial_ge};
               prem_d = trial_ge ? (trial[VAL_W-1:0] - val_q) : trial[VAL_W-1:0];
               cnt_d  = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy = (state_q != IDLE);
      acc  = acc_q;
      rem  = rem_q;
      done = done_q;
      err  = err_q;
      ovr  = ovr_q;
   end

endmodule

// File: tb/tb_calc_ctrl.sv
// tb/tb_calc_ctrl.sv - self-checking bench for calc_ctrl
// Directed literal checks followed by random stimulus against a cycle-level behavioural model.
module tb_calc_ctrl;

   logic       clk   = 1'b0;
   logic       reset = 1'b1;
   logic       go    = 1'b0;
   logic [1:0] op    = 2'd0;
   logic [3:0] val   = 4'd0;
   logic       clr   = 1'b0;
   logic [7:0] acc;
   logic [3:0] rem;
   logic       busy, done, err, ovr;

   int checks = 0;
   int errors = 0;

   calc_ctrl #(.ACC_W(8), .VAL_W(4)) dut (
      .clk(clk), .reset(reset), .go(go), .op(op), .val(val), .clr(clr),
      .acc(acc), .rem(rem), .busy(busy), .done(done), .err(err), .ovr(ovr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: a pending result plus a count of cycles left until it lands.
   int m_acc = 0, m_rem = 0, m_left = 0;
   bit m_err = 0, m_ovr = 0, m_done = 0, m_goq = 1;
   int p_acc = 0, p_rem = 0;
   bit p_div = 0, p_err = 0;

   always @(posedge clk or posedge reset) begin
      bit edge_seen;
      if (reset) begin
         m_acc = 0; m_rem = 0; m_left = 0;
         m_err = 0; m_ovr = 0; m_done = 0; m_goq = 1;
      end else begin
         edge_seen = go && !m_goq;
         m_done = 0;
         if (m_left > 0) begin
            if (edge_seen) m_ovr = 1;
            m_left--;
            if (m_left == 0) begin
               m_acc = p_acc;
               if (p_div) m_rem = p_rem;
               if (p_err) m_err = 1;
               m_done = 1;
            end
         end else if (clr) begin
            m_acc = 0;
            m_rem = 0;
         end else if (edge_seen) begin
            m_err = 0;
            m_ovr = 0;
            p_div = 0;
            p_err = 0;
            case (op)
               2'd0: p_acc = (m_acc + int'(val)) & 255;
               2'd1: p_acc = (m_acc - int'(val)) & 255;
               2'd2: p_acc = (m_acc * int'(val)) & 255;
               default: begin
                  p_div = 1;
                  if (val == 0) begin
                     p_acc = 255; p_rem = 15; p_err = 1;
                  end else begin
                     p_acc = m_acc / int'(val);
                     p_rem = m_acc % int'(val);
                  end
               end
            endcase
            m_left = (op == 2'd3) ? 9 : 1;
         end
         m_goq = go;
      end
   end

   always @(posedge clk) begin
      #2;
      chk("acc_cyc",  32'(acc),  32'(m_acc));
      chk("rem_cyc",  32'(rem),  32'(m_rem));
      chk("busy_cyc", 32'(busy), 32'(m_left > 0));
      chk("done_cyc", 32'(done), 32'(m_done));
      chk("err_cyc",  32'(err),  32'(m_err));
      chk("ovr_cyc",  32'(ovr),  32'(m_ovr));
   end

   task automatic run_cmd(input logic [1:0] o, input logic [3:0] v, output int n, output int dn);
      n = 0;
      dn = 0;
      @(negedge clk); op = o; val = v; go = 1'b1;
      @(negedge clk); go = 1'b0;
      while (busy && n < 40) begin
         n++;
         @(negedge clk);
         if (done) dn++;
      end
   endtask

   task automatic do_clr();
      @(negedge clk); clr = 1'b1;
      @(negedge clk); clr = 1'b0;
   endtask

   initial begin
      int n, dn;
      repeat (2) @(negedge clk);
      chk("rst_acc", 32'(acc), 0);
      chk("rst_rem", 32'(rem), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_err", 32'(err), 0);
      chk("rst_ovr", 32'(ovr), 0);
      reset = 1'b0;

      run_cmd(2'd0, 4'd5, n, dn);
      chk("add5_lat", 32'(n), 1);
      chk("add5_done", 32'(dn), 1);
      chk("add5_acc", 32'(acc), 5);
      run_cmd(2'd0, 4'd12, n, dn);
      chk("add12_acc", 32'(acc), 32'h11);

      do_clr();
      chk("clr_acc", 32'(acc), 0);
      chk("clr_done", 32'(done), 0);
      run_cmd(2'd0, 4'd3, n, dn);
      run_cmd(2'd1, 4'd5, n, dn);
      chk("sub_acc", 32'(acc), 32'hFE);

      do_clr();
      run_cmd(2'd0, 4'd8, n, dn);
      run_cmd(2'd2, 4'd8, n, dn);
      chk("mul_setup", 32'(acc), 32'h40);
      run_cmd(2'd2, 4'd4, n, dn);
      chk("mul_trunc", 32'(acc), 0);

      do_clr();
      run_cmd(2'd0, 4'd10, n, dn);
      run_cmd(2'd2, 4'd10, n, dn);
      run_cmd(2'd3, 4'd7, n, dn);
      chk("div_lat", 32'(n), 9);
      chk("div_done", 32'(dn), 1);
      chk("div_acc", 32'(acc), 14);
      chk("div_rem", 32'(rem), 2);
      chk("div_err", 32'(err), 0);

      do_clr();
      run_cmd(2'd0, 4'd10, n, dn);
      run_cmd(2'd2, 4'd5, n, dn);
      run_cmd(2'd3, 4'd0, n, dn);
      chk("div0_lat", 32'(n), 9);
      chk("div0_acc", 32'(acc), 32'hFF);
      chk("div0_rem", 32'(rem), 32'hF);
      chk("div0_err", 32'(err), 1);
      run_cmd(2'd0, 4'd1, n, dn);
      chk("div0_add_acc", 32'(acc), 0);
      chk("div0_add_err", 32'(err), 0);

      do_clr();
      run_cmd(2'd0, 4'd10, n, dn);
      run_cmd(2'd2, 4'd10, n, dn);
      @(negedge clk); op = 2'd3; val = 4'd7; go = 1'b1;
      @(negedge clk); go = 1'b0;
      @(negedge clk);
      @(negedge clk); go = 1'b1; op = 2'd0; val = 4'd1;
      @(negedge clk); go = 1'b0;
      n = 0;
      while (busy && n < 40) begin n++; @(negedge clk); end
      chk("ovr_flag", 32'(ovr), 1);
      chk("ovr_acc", 32'(acc), 14);
      chk("ovr_rem", 32'(rem), 2);

      @(negedge clk); clr = 1'b1; go = 1'b1; op = 2'd0; val = 4'd5;
      @(negedge clk); clr = 1'b0; go = 1'b0;
      chk("clrgo_acc", 32'(acc), 0);
      chk("clrgo_done", 32'(done), 0);
      chk("clrgo_ovr", 32'(ovr), 1);
      @(negedge clk);
      chk("clrgo_busy", 32'(busy), 0);
      chk("clrgo_done2", 32'(done), 0);

      run_cmd(2'd0, 4'd9, n, dn);
      @(negedge clk); op = 2'd3; val = 4'd2; go = 1'b1;
      repeat (4) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("rstdiv_acc", 32'(acc), 0);
      chk("rstdiv_busy", 32'(busy), 0);
      chk("rstdiv_done", 32'(done), 0);
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("held_busy", 32'(busy), 0);
         chk("held_acc", 32'(acc), 0);
         chk("held_done", 32'(done), 0);
      end
      go = 1'b0;
      @(negedge clk); go = 1'b1; op = 2'd0; val = 4'd6;
      @(negedge clk); go = 1'b0;
      chk("rearm_busy", 32'(busy), 1);
      @(negedge clk);
      chk("rearm_acc", 32'(acc), 6);
      chk("rearm_done", 32'(done), 1);

      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         reset = ($urandom_range(0, 599) == 0);
         go    = ($urandom_range(0, 9) < 4);
         op    = 2'($urandom_range(0, 3));
         val   = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
         clr   = ($urandom_range(0, 19) == 0);
      end
      @(negedge clk);
      reset = 1'b0; go = 1'b0; clr = 1'b0;
      repeat (12) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/calc_ctrl.md
CALC_CTRL -- requirements
Module: calc_ctrl

Interface
REQ-001 Parameter ACC_W, default 8: accumulator/result width; all values in this document assume 8.
REQ-002 Parameter VAL_W, default 4: operand width from the switches.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 go  input  1  command strobe, level, already debounced; a rising edge requests one operation.
REQ-006 op  input  2  operation: 00 add, 01 sub, 10 mul, 11 div.
REQ-007 val  input  VAL_W  operand, zero-extended to ACC_W.
REQ-008 clr  input  1  level; clears the accumulator.
REQ-009 acc  output  ACC_W  accumulator, the running result.
REQ-010 rem  output  VAL_W  remainder of the last divide.
REQ-011 busy  output  1  high while a command is executing.
REQ-012 done  output  1  one-cycle pulse when acc is written by a command.
REQ-013 err  output  1  sticky divide-by-zero flag.
REQ-014 ovr  output  1  sticky flag for a command dropped while busy.

Function
REQ-015 The block SHALL register go into go_q every cycle; a go edge is go=1 and go_q=0.
REQ-016 The FSM SHALL have three states: IDLE, EXEC and DIV.
REQ-017 In IDLE, a go edge with clr=0 SHALL capture op and val at edge k and set busy=1; op 00/01/10 goes to EXEC, op 11 goes to DIV.
REQ-018 In EXEC, at edge k+1 the block SHALL write acc = acc+val, acc-val or acc*val, each truncated modulo 2^ACC_W, pulse done, return to IDLE and set busy=0.
REQ-019 In DIV, the block SHALL run a restoring divide of acc by the zero-extended val, producing one quotient bit per cycle, MSB first, for exactly ACC_W cycles (edges k+1..k+8).
REQ-020 At edge k+9 the block SHALL write acc=quotient and rem=remainder, pulse done, return to IDLE and set busy=0.
REQ-021 Divide latency SHALL be 9 cycles; add/sub/mul latency SHALL be 1 cycle.
REQ-022 A divide with val=0 SHALL take the same 9 cycles, write acc=8'hFF and rem=4'hF, and set err.
REQ-023 Intermediate divide state SHALL NOT be visible on acc until the final write.
REQ-024 A go edge while busy SHALL be dropped, leaving acc and the executing command unaffected, and SHALL set ovr.
REQ-025 err and ovr SHALL clear on the next accepted command; if that command sets the flag again, set wins.
REQ-026 clr=1 in IDLE SHALL set acc=0 and rem=0 at the next edge, without pulsing done and without touching err/ovr.
REQ-027 clr and a go edge in the same IDLE cycle: clr wins and the go edge is consumed without executing.
REQ-028 clr=1 while busy SHALL be ignored.
REQ-029 A held go, op or val change during execution SHALL NOT affect the running command; only a new rising edge starts another command.
REQ-030 done SHALL be registered and SHALL never be high in two consecutive cycles; back-to-back commands are at least 2 cycles apart.

Reset
REQ-031 While reset is high, asynchronously: state=IDLE, acc=0, rem=0, go_q=1, busy=0, done=0, err=0, ovr=0.
REQ-032 Setting go_q=1 at reset SHALL prevent a go held high through reset from producing a spurious edge.
REQ-033 Reset mid-divide SHALL abandon the operation, leave acc at 0, and produce no done pulse.

Verification
REQ-034 From reset, add val=5, then add val=12: acc=5 with done at k+1, then acc=17 (8'h11).
REQ-035 acc=3, sub val=5: acc=8'hFE. acc=8'h40, mul val=4: acc=8'h00 (truncated).
REQ-036 acc=100, div val=7: busy high 9 cycles, acc=14, rem=2, one done pulse, err=0.
REQ-037 acc=50, div val=0: acc=8'hFF, rem=4'hF, err=1; the next add val=1 gives acc=0 and err=0.
REQ-038 Go edge issued 3 cycles into a divide: command dropped, ovr=1, divide result correct; clr and go edge together in IDLE: acc=0, no done.
REQ-039 Reset asserted at cycle 4 of a divide with go held high through reset: all outputs 0 and no command after release until go falls and rises again.
